// File: rtl/addr_arb_pkg.sv
// Shared types, widths and the round-robin search function for addr_rr_arbiter.
package addr_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned MAX_N  = 8;
   localparam int unsigned GNT_W  = 3;

   typedef logic [ADDR_W-1:0] addr_t;

   // First valid requester after 'last', wrapping modulo n; returns 'last' when none is valid.
   function automatic logic [GNT_W-1:0] next_grant(input logic [MAX_N-1:0] valid,
                                                   input logic [GNT_W-1:0] last,
                                                   input int unsigned      n);
      logic [GNT_W-1:0] g;
      logic             found;
      int unsigned      idx;
      g     = last;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_N; k++) begin
         if (k <= n && !found) begin
            idx = (32'(last) + k) % n;
            if (valid[GNT_W'(idx)]) begin
               g     = GNT_W'(idx);
               found = 1'b1;
            end
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/addr_rr_arbiter_if.sv
// Request, downstream and response channels of addr_rr_arbiter.
interface addr_rr_arbiter_if
   import addr_arb_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned SRC_W = $clog2(N)
);
   logic [N-1:0]        io_in_valid;
   logic [N-1:0]        io_in_ready;
   logic [N*ADDR_W-1:0] io_in_bits_address;
   logic                io_out_valid;
   logic                io_out_ready;
   addr_t               io_out_bits_address;
   logic [SRC_W-1:0]    io_out_bits_source;
   logic                io_resp_valid;
   logic                io_resp_ready;
   logic [ADDR_W-1:0]   io_resp_bits_data;
   logic [N-1:0]        io_in_resp_valid;
   logic [N-1:0]        io_in_resp_ready;
   logic [N*ADDR_W-1:0] io_in_resp_bits_data;

   // Arbiter side.
   modport slave (
      input  io_in_valid, io_in_bits_address, io_out_ready,
             io_resp_valid, io_resp_bits_data, io_in_resp_ready,
      output io_in_ready, io_out_valid, io_out_bits_address, io_out_bits_source,
             io_resp_ready, io_in_resp_valid, io_in_resp_bits_data
   );

   // Requesters plus downstream side.
   modport master (
      output io_in_valid, io_in_bits_address, io_out_ready,
             io_resp_valid, io_resp_bits_data, io_in_resp_ready,
      input  io_in_ready, io_out_valid, io_out_bits_address, io_out_bits_source,
             io_resp_ready, io_in_resp_valid, io_in_resp_bits_data
   );
endinterface

// File: rtl/addr_arb_src_fifo.sv
// Source-index FIFO: remembers which requester issued each outstanding request.
module addr_arb_src_fifo #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW    = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/addr_rr_arbiter.sv
// Round-robin address arbiter with registered output and in-order response steering.
// Optional per-requester saturating grant counters: define ADDR_ARB_GRANT_CNT_EN.
module addr_rr_arbiter
   import addr_arb_pkg::*;
#(
   parameter int unsigned N               = 4,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned SRC_W           = $clog2(N)
) (
   input  logic                 clock,
   input  logic                 reset,
   addr_rr_arbiter_if.slave     bus
`ifdef ADDR_ARB_GRANT_CNT_EN
   ,
   output logic [N*CNT_W-1:0]   io_grant_count
`endif
);
   addr_t            in_addr [N];
   logic [MAX_N-1:0] valid_ext;
   logic [SRC_W-1:0] gnt;
   logic [SRC_W-1:0] last_q;
   logic             can_load;
   logic             accept;
   logic             out_valid_q;
   addr_t            out_addr_q;
   logic [SRC_W-1:0] out_src_q;
   logic             fifo_full;
   logic             fifo_empty;
   logic [SRC_W-1:0] head;
   logic             resp_pop;
   logic [N-1:0]     in_ready;

   for (genvar g = 0; g < N; g++) begin : g_addr
      assign in_addr[g] = bus.io_in_bits_address[g*ADDR_W +: ADDR_W];
   end

   always_comb begin
      valid_ext        = '0;
      valid_ext[N-1:0] = bus.io_in_valid;
   end

   assign gnt      = SRC_W'(next_grant(valid_ext, GNT_W'(last_q), N));
   assign can_load = !out_valid_q || bus.io_out_ready;

   // Only the round-robin winner sees ready; a full FIFO blocks even with a same-cycle pop.
   always_comb begin
      in_ready = '0;
      if (reset && can_load && !fifo_full) in_ready[gnt] = 1'b1;
   end

   assign bus.io_in_ready = in_ready;
   assign accept          = |(bus.io_in_valid & in_ready);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_src_q   <= '0;
         last_q      <= SRC_W'(N-1);
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_addr_q  <= in_addr[gnt];
         out_src_q   <= gnt;
         last_q      <= gnt;
      end else if (bus.io_out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.io_out_valid        = out_valid_q;
   assign bus.io_out_bits_address = out_addr_q;
   assign bus.io_out_bits_source  = out_src_q;

   addr_arb_src_fifo #(
      .WIDTH (SRC_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_src_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (accept),
      .push_data (gnt),
      .pop       (resp_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   // Responses return in request order, so the FIFO head names the destination lane.
   always_comb begin
      bus.io_in_resp_valid = '0;
      if (!fifo_empty) bus.io_in_resp_valid[head] = bus.io_resp_valid;
   end

   assign bus.io_resp_ready        = !fifo_empty && bus.io_in_resp_ready[head];
   assign resp_pop                 = bus.io_resp_valid && bus.io_resp_ready;
   assign bus.io_in_resp_bits_data = {N{bus.io_resp_bits_data}};

`ifdef ADDR_ARB_GRANT_CNT_EN
   logic [CNT_W-1:0] cnt_q [N];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (accept && gnt == SRC_W'(i) && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_cnt
      assign io_grant_count[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`endif

endmodule

// File: doc/addr_rr_arbiter.md
# addr_rr_arbiter

Round-robin arbiter sharing one 32-bit address request channel among `N` requesters, with a registered output stage and in-order response routing. Replaces fixed-priority arbitration where starvation of low-index requesters is unacceptable. A source-index FIFO records the requester of each accepted request and steers each returning response to that requester. Sits between the requesters and the shared downstream port.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8
- `MAX_OUTSTANDING`, 4: source FIFO depth (power of 2), i.e. the cap on outstanding requests
- `SRC_W`, `$clog2(N)`: source index width

Ports:
- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `io_in_valid`  in  N  per-requester request valid
- `io_in_ready`  out  N  per-requester request ready
- `io_in_bits_address`  in  N*32  request addresses, requester i at bits [32i+31:32i]
- `io_out_valid`  out  1  downstream request valid
- `io_out_ready`  in  1  downstream request ready
- `io_out_bits_address`  out  32  granted address
- `io_out_bits_source`  out  SRC_W  index of the granted requester
- `io_resp_valid`  in  1  downstream response valid
- `io_resp_ready`  out  1  downstream response ready
- `io_resp_bits_data`  in  32  response data
- `io_in_resp_valid`  out  N  per-requester response valid
- `io_in_resp_ready`  in  N  per-requester response ready
- `io_in_resp_bits_data`  out  N*32  response data, broadcast to all requester lanes

## Operation
- **Output register (one entry).**
  - `can_load = !out_valid_q || io_out_ready`.
- **Arbitration.**
  - Arbitration runs every cycle over `io_in_valid`.
  - Search order starts at `last_q+1` and wraps modulo N.
  - The first valid requester is `gnt`.
  - `io_in_ready[i] = (i == gnt) && can_load && !fifo_full`.
  - All other bits of `io_in_ready` are 0.
- **Accept** (`io_in_valid[gnt] && io_in_ready[gnt]`):
  - load the address and `gnt` into the output register;
  - set `out_valid_q`;
  - push `gnt` into the source FIFO;
  - set `last_q <= gnt`.
- **Drain.** `io_out_valid && io_out_ready` with no accept in the same cycle clears `out_valid_q`.
- **Source FIFO full.** No request is accepted. This holds even if a pop occurs in the same cycle; push-when-full is never bypassed.
- **Response routing.**
  - `head` is the FIFO head entry.
  - `io_in_resp_valid[head] = io_resp_valid && !fifo_empty`; every other bit is 0.
  - `io_resp_ready = !fifo_empty && io_in_resp_ready[head]`.
  - A response handshake pops the FIFO.
- **FIFO empty.** `io_resp_ready = 0`. A response arriving while the FIFO is empty stalls; it is a protocol error and is not routed.
- **Simultaneous push and pop (FIFO not full).** Both occur; the count is unchanged.
- **Held requests.** A requester holding valid is not overtaken twice before it is granted, because the round-robin pointer only advances on accept.

## Timing
- **Reset values:**
  - `io_out_valid` = 0 and `io_out_bits_*` = 0;
  - `last_q` = N-1, so requester 0 has first priority;
  - FIFO empty, so `io_resp_ready` = 0 and `io_in_resp_valid` = 0;
  - `io_in_ready` forced to 0 while `reset` is low.
- **Request latency:** 1 cycle from accept to `io_out_valid`.
- **Throughput:** 1 request per cycle while `io_out_ready` is high and the FIFO is not full.
- **Response path:** combinational, 0 cycles.
- **Handshake rule:** `io_out_valid` and `io_out_bits_*` stay stable until the downstream handshake.
- **Reset mid-operation:** asserting `reset` clears the output register, FIFO and `last_q` immediately. In-flight requests and responses are discarded.

## Configuration
- **`ADDR_ARB_GRANT_CNT_EN` defined:**
  - adds output `io_grant_count`, N*16 bits;
  - one saturating 16-bit counter per requester, incremented on each accept by that requester;
  - counters reset to 0 and hold at 0xFFFF.
- **`ADDR_ARB_GRANT_CNT_EN` undefined:** the port and counters are absent. All other behaviour is identical.

## Structure
- **Package `addr_arb_pkg`:**
  - `ADDR_W = 32`;
  - `CNT_W = 16`;
  - `typedef logic [ADDR_W-1:0] addr_t`;
  - the round-robin `next_grant` function.
- **Sub-module `addr_arb_src_fifo`:** source-index FIFO with parameters WIDTH and DEPTH, outputs full, empty and head.

## Test plan
- **Single requester:** reset, then requester 2 sends address 0x1000_0040 with `io_out_ready` = 1 → next cycle `io_out_valid` = 1, address 0x1000_0040, source 2.
- **Round-robin fairness:** all 4 requesters valid continuously with `io_out_ready` = 1 → grant order 0,1,2,3,0,… for 8 cycles, one grant per cycle.
- **Backpressure:** `io_out_ready` = 0 for 5 cycles with requester 1 valid → `io_out_valid` held with the same address; exactly one accept; `io_in_ready` = 0 after the first accept until drained.
- **Outstanding cap:** `MAX_OUTSTANDING` = 4, 4 requests accepted, no responses → all `io_in_ready` = 0. One response popped → next cycle one accept allowed.
- **Response routing:** requests accepted from sources 3,0,3, then responses 0xA,0xB,0xC → delivered on lanes 3,0,3 in order. With `io_in_resp_ready[0]` = 0, `io_resp_ready` = 0 while 0xB is at the head.
- **Counter saturation:** with the macro defined, 70000 grants to requester 0 → `io_grant_count[15:0]` = 0xFFFF and other lanes 0. Reset mid-stream → all counters 0, `io_out_valid` = 0.
